// File: rtl/sram_lsu_ctrl_if.sv
// Request/response and SRAM strobe bundle for the load/store controller.
// slave = controller side; master = requester plus SRAM side.
interface sram_lsu_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_cs;
  logic        mem_oe;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_dout,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_cs, mem_oe, mem_we, mem_addr, mem_din
  );

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_dout,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_cs, mem_oe, mem_we, mem_addr, mem_din
  );
endinterface

// File: rtl/sram_lsu_ctrl.sv
// Byte/half/word load-store controller for a word-wide SRAM without byte enables.
// Sub-word stores are read-modify-write; all outputs are registered.
module sram_lsu_ctrl #(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter bit          BIG_ENDIAN  = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  sram_lsu_ctrl_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    RD,
    MERGE,
    WR,
    RESP
  } state_t;

  state_t      state;
  logic [3:0]  wait_cnt;
  logic        op_we;
  logic [1:0]  op_size;
  logic        op_signed;
  logic [1:0]  op_lane;
  logic [31:0] op_wdata;
  logic        req_err;

  always_comb begin
    req_err = 1'b0;
    case (bus.req_size)
      2'b01:   req_err = bus.req_addr[0];
      2'b10:   req_err = (bus.req_addr[1:0] != 2'b00);
      2'b11:   req_err = 1'b1;
      default: req_err = 1'b0;
    endcase
  end

  // Big-endian lane mapping is a mirror of the physical byte/half position.
  function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] size,
                                           input logic [1:0] lane, input logic sgn);
    logic [1:0]  bp;
    logic        hp;
    logic [7:0]  b;
    logic [15:0] h;
    bp = BIG_ENDIAN ? ~lane : lane;
    hp = BIG_ENDIAN ? ~lane[1] : lane[1];
    b  = w[{bp, 3'b000} +: 8];
    h  = w[{hp, 4'b0000} +: 16];
    case (size)
      2'b00:   load_ext = {{24{sgn & b[7]}}, b};
      2'b01:   load_ext = {{16{sgn & h[15]}}, h};
      default: load_ext = w;
    endcase
  endfunction

  function automatic logic [31:0] merge_word(input logic [31:0] w, input logic [1:0] size,
                                             input logic [1:0] lane, input logic [31:0] wd);
    logic [1:0] bp;
    logic       hp;
    bp = BIG_ENDIAN ? ~lane : lane;
    hp = BIG_ENDIAN ? ~lane[1] : lane[1];
    merge_word = w;
    if (size == 2'b00) merge_word[{bp, 3'b000} +: 8] = wd[7:0];
    else               merge_word[{hp, 4'b0000} +: 16] = wd[15:0];
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      wait_cnt       <= '0;
      op_we          <= 1'b0;
      op_size        <= '0;
      op_signed      <= 1'b0;
      op_lane        <= '0;
      op_wdata       <= '0;
      bus.req_ready  <= 1'b1;
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= '0;
      bus.resp_err   <= 1'b0;
      bus.mem_cs     <= 1'b0;
      bus.mem_oe     <= 1'b0;
      bus.mem_we     <= 1'b0;
      bus.mem_addr   <= '0;
      bus.mem_din    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            op_we         <= bus.req_we;
            op_size       <= bus.req_size;
            op_signed     <= bus.req_signed;
            op_lane       <= bus.req_addr[1:0];
            op_wdata      <= bus.req_wdata;
            bus.req_ready <= 1'b0;
            if (req_err) begin
              bus.resp_valid <= 1'b1;
              bus.resp_err   <= 1'b1;
              bus.resp_rdata <= '0;
              state          <= RESP;
            end else begin
              bus.mem_addr <= {bus.req_addr[31:2], 2'b00};
              bus.mem_din  <= bus.req_wdata;
              state        <= SETUP;
            end
          end
        end
        SETUP: begin
          if (op_we && op_size == 2'b10) begin
            bus.mem_cs <= 1'b1;
            bus.mem_we <= 1'b1;
            state      <= WR;
          end else begin
            bus.mem_cs <= 1'b1;
            bus.mem_oe <= 1'b1;
            wait_cnt   <= 4'(WAIT_CYCLES - 1);
            state      <= RD;
          end
        end
        RD: begin
          if (wait_cnt == '0) begin
            bus.mem_cs <= 1'b0;
            bus.mem_oe <= 1'b0;
            if (op_we) begin
              bus.mem_din <= merge_word(bus.mem_dout, op_size, op_lane, op_wdata);
              state       <= MERGE;
            end else begin
              bus.resp_valid <= 1'b1;
              bus.resp_rdata <= load_ext(bus.mem_dout, op_size, op_lane, op_signed);
              state          <= RESP;
            end
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        MERGE: begin
          bus.mem_cs <= 1'b1;
          bus.mem_we <= 1'b1;
          state      <= WR;
        end
        WR: begin
          bus.mem_cs     <= 1'b0;
          bus.mem_we     <= 1'b0;
          bus.resp_valid <= 1'b1;
          bus.resp_rdata <= '0;
          state          <= RESP;
        end
        RESP: begin
          bus.resp_valid <= 1'b0;
          bus.resp_rdata <= '0;
          bus.resp_err   <= 1'b0;
          bus.req_ready  <= 1'b1;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_lsu_ctrl.sv
// Bench for sram_lsu_ctrl: a little-endian WAIT_CYCLES=1 instance and a big-endian
// WAIT_CYCLES=3 instance, each on its own SRAM, checked against a byte-addressed model.
module tb_sram_lsu_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst [2];
  logic        req_valid [2];
  logic        req_we [2];
  logic [1:0]  req_size [2];
  logic        req_signed [2];
  logic [31:0] req_addr [2];
  logic [31:0] req_wdata [2];
  logic        ready_o [2];
  logic        rv [2];
  logic [31:0] rdata [2];
  logic        rerr [2];
  logic        cs [2];
  logic        oe [2];
  logic        we [2];
  logic [31:0] maddr [2];
  logic [31:0] mdin [2];
  logic        bk_we [2];
  logic [3:0]  bk_addr [2];
  logic [31:0] bk_data [2];

  logic [31:0] ref_mem [2][16];

  int checks = 0;
  int failures = 0;

  for (genvar g = 0; g < 2; g++) begin : gen_dut
    sram_lsu_ctrl_if bus ();
    logic [31:0] mem [16];

    sram_lsu_ctrl #(
      .WAIT_CYCLES(g == 0 ? 1 : 3),
      .BIG_ENDIAN (g == 1)
    ) u_dut (
      .clk  (clk),
      .reset(rst[g]),
      .bus  (bus)
    );

    assign bus.req_valid  = req_valid[g];
    assign bus.req_we     = req_we[g];
    assign bus.req_size   = req_size[g];
    assign bus.req_signed = req_signed[g];
    assign bus.req_addr   = req_addr[g];
    assign bus.req_wdata  = req_wdata[g];
    assign ready_o[g]     = bus.req_ready;
    assign rv[g]          = bus.resp_valid;
    assign rdata[g]       = bus.resp_rdata;
    assign rerr[g]        = bus.resp_err;
    assign cs[g]          = bus.mem_cs;
    assign oe[g]          = bus.mem_oe;
    assign we[g]          = bus.mem_we;
    assign maddr[g]       = bus.mem_addr;
    assign mdin[g]        = bus.mem_din;

    // Behavioural SRAM; garbage on dout when not selected for reading.
    assign bus.mem_dout = (bus.mem_cs && bus.mem_oe) ? mem[bus.mem_addr[5:2]] : 32'hDEAD_BEEF;
    always @(posedge clk) begin
      if (bk_we[g]) mem[bk_addr[g]] <= bk_data[g];
      else if (bus.mem_cs && bus.mem_we) mem[bus.mem_addr[5:2]] <= bus.mem_din;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, want);
    end
  endtask

  function automatic int lane_shift(input int d, input logic [31:0] a);
    return (d == 1) ? (3 - int'(a[1:0])) * 8 : int'(a[1:0]) * 8;
  endfunction

  function automatic logic [31:0] get_byte(input int d, input logic [31:0] a);
    return (ref_mem[d][a[5:2]] >> lane_shift(d, a)) & 32'hFF;
  endfunction

  task automatic set_byte(input int d, input logic [31:0] a, input logic [7:0] v);
    logic [31:0] w;
    w = ref_mem[d][a[5:2]];
    w = (w & ~(32'hFF << lane_shift(d, a))) | ({24'h0, v} << lane_shift(d, a));
    ref_mem[d][a[5:2]] = w;
  endtask

  function automatic logic [31:0] model_load(input int d, input logic [1:0] size,
                                             input logic sgn, input logic [31:0] a);
    logic [31:0] lo, hi, v;
    if (size == 2'b00) begin
      v = get_byte(d, a);
      if (sgn && v[7]) v = v | 32'hFFFF_FF00;
    end else if (size == 2'b01) begin
      lo = get_byte(d, a);
      hi = get_byte(d, a + 1);
      v  = (d == 1) ? ((lo << 8) | hi) : ((hi << 8) | lo);
      if (sgn && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = ref_mem[d][a[5:2]];
    end
    return v;
  endfunction

  task automatic model_store(input int d, input logic [1:0] size, input logic [31:0] a,
                             input logic [31:0] wd);
    if (size == 2'b00) set_byte(d, a, wd[7:0]);
    else if (size == 2'b01) begin
      set_byte(d, a,     (d == 1) ? wd[15:8] : wd[7:0]);
      set_byte(d, a + 1, (d == 1) ? wd[7:0]  : wd[15:8]);
    end else ref_mem[d][a[5:2]] = wd;
  endtask

  // Issues one request and checks latency, response, strobe activity and write data.
  task automatic run(input int d, input logic wr, input logic [1:0] size, input logic sgn,
                     input logic [31:0] addr, input logic [31:0] wdata, input bit hold,
                     input string tag);
    int w_cyc, exp_lat, exp_rdc, exp_wrc;
    int lat, rdc, wrc, ovl, rdy_busy, addr_bad;
    logic [31:0] exp_rd, exp_din, addr0, din_seen;
    bit err;
    w_cyc   = (d == 0) ? 1 : 3;
    err     = (size == 2'b11) || (size == 2'b01 && addr[0]) ||
              (size == 2'b10 && addr[1:0] != 2'b00);
    exp_rd  = 32'h0;
    exp_din = 32'h0;
    exp_rdc = 0;
    exp_wrc = 0;
    if (err) exp_lat = 1;
    else if (!wr) begin
      exp_lat = 2 + w_cyc;
      exp_rdc = w_cyc;
      exp_rd  = model_load(d, size, sgn, addr);
    end else begin
      exp_lat = (size == 2'b10) ? 3 : 4 + w_cyc;
      exp_rdc = (size == 2'b10) ? 0 : w_cyc;
      exp_wrc = 1;
      model_store(d, size, addr, wdata);
      exp_din = ref_mem[d][addr[5:2]];
    end
    addr0 = maddr[d];
    req_we[d]     = wr;
    req_size[d]   = size;
    req_signed[d] = sgn;
    req_addr[d]   = addr;
    req_wdata[d]  = wdata;
    req_valid[d]  = 1'b1;
    check({tag, "_ready_idle"}, 32'(ready_o[d]), 32'd1);
    @(posedge clk); #1;
    if (!hold) begin
      req_valid[d]  = 1'b0;
      req_we[d]     = 1'($urandom);
      req_size[d]   = 2'($urandom);
      req_signed[d] = 1'($urandom);
      req_addr[d]   = $urandom;
      req_wdata[d]  = $urandom;
    end
    lat = 1; rdc = 0; wrc = 0; ovl = 0; rdy_busy = 0; addr_bad = 0; din_seen = 32'h0;
    while (1) begin
      if (cs[d] && oe[d]) rdc++;
      if (cs[d] && we[d]) begin wrc++; din_seen = mdin[d]; end
      if (oe[d] && we[d]) ovl++;
      if (cs[d] && maddr[d] !== {addr[31:2], 2'b00}) addr_bad++;
      if (err && maddr[d] !== addr0) addr_bad++;
      if (ready_o[d]) rdy_busy++;
      if (rv[d] === 1'b1 || lat >= 40) break;
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_err"}, 32'(rerr[d]), 32'(err));
    check({tag, "_rdata"}, rdata[d], exp_rd);
    check({tag, "_rd_cycles"}, 32'(rdc), 32'(exp_rdc));
    check({tag, "_wr_cycles"}, 32'(wrc), 32'(exp_wrc));
    check({tag, "_oe_we_overlap"}, 32'(ovl), 32'd0);
    check({tag, "_addr"}, 32'(addr_bad), 32'd0);
    check({tag, "_ready_busy"}, 32'(rdy_busy), 32'd0);
    if (exp_wrc != 0) check({tag, "_din"}, din_seen, exp_din);
    @(posedge clk); #1;
    check({tag, "_resp_drop"}, {rdata[d][29:0], rerr[d], rv[d]}, 32'h0);
    check({tag, "_ready_back"}, 32'(ready_o[d]), 32'd1);
  endtask

  initial begin
    int k, seen;
    logic [31:0] rw;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; req_valid[d] = 1'b0; req_we[d] = 1'b0; req_size[d] = 2'b00;
      req_signed[d] = 1'b0; req_addr[d] = '0; req_wdata[d] = '0; bk_we[d] = 1'b0;
      bk_addr[d] = '0; bk_data[d] = '0;
    end
    for (int w = 0; w < 16; w++) begin
      for (int d = 0; d < 2; d++) begin
        rw = (w == 4) ? 32'h8899_AABB : $urandom;
        ref_mem[d][w] = rw;
        bk_we[d] = 1'b1; bk_addr[d] = 4'(w); bk_data[d] = rw;
      end
      @(posedge clk); #1;
    end
    for (int d = 0; d < 2; d++) begin
      bk_we[d] = 1'b0;
      check("reset_ready", 32'(ready_o[d]), 32'd1);
      check("reset_strobes", {29'h0, cs[d], oe[d], we[d]}, 32'h0);
      check("reset_resp", {rdata[d][29:0], rerr[d], rv[d]}, 32'h0);
      check("reset_mem_addr", maddr[d], 32'h0);
      check("reset_mem_din", mdin[d], 32'h0);
      rst[d] = 1'b0;
    end
    @(posedge clk); #1;

    run(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, "lw10");
    run(0, 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 1'b0, "lb13");
    run(0, 1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 1'b0, "lbu11");
    run(0, 1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 1'b0, "lh12");
    run(0, 1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 1'b0, "lhu10");
    run(0, 1'b1, 2'b00, 1'b0, 32'h12, 32'h1234_5655, 1'b0, "sb12");
    run(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, "lw10_after_sb");
    run(0, 1'b0, 2'b01, 1'b0, 32'h11, 32'h0, 1'b0, "lh11_err");
    run(0, 1'b0, 2'b10, 1'b0, 32'h12, 32'h0, 1'b0, "lw12_err");
    run(0, 1'b1, 2'b11, 1'b0, 32'h14, 32'h0, 1'b0, "size11_err");

    // Reset during the write cycle of a word store.
    req_we[0] = 1'b1; req_size[0] = 2'b10; req_addr[0] = 32'h20; req_wdata[0] = $urandom;
    req_valid[0] = 1'b1;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    k = 0;
    while (!(cs[0] && we[0]) && k < 10) begin @(posedge clk); #1; k++; end
    check("rst_reach_wr", 32'(cs[0] && we[0]), 32'd1);
    #2 rst[0] = 1'b1;
    #1;
    check("rst_strobes_drop", {29'h0, cs[0], oe[0], we[0]}, 32'h0);
    check("rst_ready", 32'(ready_o[0]), 32'd1);
    check("rst_no_resp", 32'(rv[0]), 32'd0);
    @(posedge clk); #1;
    rst[0] = 1'b0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (rv[0]) seen++;
      @(posedge clk); #1;
    end
    check("rst_no_resp_after", 32'(seen), 32'd0);
    run(0, 1'b1, 2'b10, 1'b0, 32'h20, 32'hCAFE_F00D, 1'b0, "sw20_after_rst");
    run(0, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0, "lw20_after_rst");

    run(1, 1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 1'b1, "be_lbu10_hold");
    run(1, 1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 1'b0, "be_lhu12");
    run(1, 1'b1, 2'b01, 1'b0, 32'h10, 32'h0000_1357, 1'b0, "be_sh10");
    run(1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, "be_lw10");

    for (int i = 0; i < 80; i++) begin
      run(i % 2, 1'($urandom), 2'($urandom), 1'($urandom), 32'($urandom_range(0, 63)),
          $urandom, 1'b0, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_lsu_ctrl.md
Name: sram_lsu_ctrl

Overview:
- Load/store controller between the processor datapath and the word-organised behavioural SRAM (cs/oe/we/addr/din/dout interface).
- Accepts byte, halfword and word load/store requests through a valid/ready handshake and returns one response per request.
- Performs sub-word stores as read-modify-write, because the SRAM has no byte enables.
- Sequences SRAM strobes so that address and data are always stable one cycle before any strobe rises; the SRAM is event-driven, so this avoids simulation races.

Parameters:
- WAIT_CYCLES, 1: cycles cs+oe are held in a read before dout is sampled (range 1..15).
- BIG_ENDIAN, 0: 0 means byte lane 0 = dout[7:0]; 1 means byte lane 0 = dout[31:24].

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = reserved
- req_signed  in  1  sign-extend loads (ignored for word and stores)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  one-cycle response strobe
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  misaligned or reserved-size request
- mem_cs  out  1  SRAM chip select
- mem_oe  out  1  SRAM output enable
- mem_we  out  1  SRAM write enable
- mem_addr  out  32  word address, {req_addr[31:2],2'b00}
- mem_din  out  32  SRAM write data
- mem_dout  in  32  SRAM read data

Behaviour:
- Reset (async): state = IDLE; all outputs 0 except req_ready = 1.
  - If reset asserts mid-operation, strobes drop immediately and the pending request is discarded with no response.
  - A write interrupted by reset may or may not have updated the SRAM.
- All outputs are registered. Every strobe rises and falls on a clk edge.
- Handshake: accept on an edge where req_valid && req_ready. req_ready = 1 only in IDLE. req_* are latched at accept and ignored thereafter, so the requester may change them.
- States:
  - IDLE
  - SETUP: mem_addr/mem_din driven, strobes low, one cycle
  - RD: cs = oe = 1 for WAIT_CYCLES cycles; mem_dout captured on the final RD edge
  - MERGE: strobes low; mem_din = captured word with the target lane(s) replaced, one cycle
  - WR: cs = we = 1, oe = 0, one cycle
  - RESP: resp_valid = 1, one cycle
- Transitions:
  - Error request: IDLE -> RESP with resp_err = 1. No strobe toggles and mem_addr is unchanged.
  - Load: IDLE -> SETUP -> RD -> RESP.
  - SW: IDLE -> SETUP -> WR -> RESP, with mem_din = req_wdata.
  - SH/SB: IDLE -> SETUP -> RD -> MERGE -> WR -> RESP.
  - RESP -> IDLE. A new request can be accepted on the edge after the RESP cycle (req_ready high in IDLE).
- Latency, from accept edge to resp_valid high, with WAIT_CYCLES = 1:
  - load 3
  - SW 3
  - SB/SH 5
  - error 1
  - Each extra WAIT_CYCLES adds 1 to loads and sub-word stores.
- Errors:
  - size 11 is an error.
  - Half with addr[0] = 1 is an error.
  - Word with addr[1:0] != 0 is an error.
- Lanes:
  - Byte lane = addr[1:0]; half lane = addr[1] (bytes 2*addr[1], +1).
  - BIG_ENDIAN selects the byte-to-bit mapping. Within a half, the lower-addressed byte is least significant when BIG_ENDIAN = 0 and most significant when BIG_ENDIAN = 1.
- Extension:
  - signed: replicate bit 7 (byte) or bit 15 (half).
  - unsigned: zero-fill.
- mem_oe and mem_we are never both 1. cs is 0 outside RD/WR.
- resp_rdata and resp_err hold their value only during RESP and are 0 otherwise.

Test Plan:
- Preload 0x10 = 0x8899AABB. LW 0x10 -> resp_rdata 0x8899AABB, err 0, resp 3 cycles after accept, cs/oe high exactly 1 cycle, we never high.
- LB signed 0x13 -> 0xFFFFFF88. LBU 0x11 -> 0x000000AA. LH signed 0x12 -> 0xFFFF8899. LHU 0x10 -> 0x0000AABB.
- SB 0x12, wdata 0x12345655 -> 5-cycle latency, one RD then one WR with mem_din 0x8855AABB; subsequent LW 0x10 returns 0x8855AABB.
- LH 0x11 and LW 0x12 -> resp_err 1, rdata 0, resp 1 cycle after accept, cs/oe/we never toggle.
- Assert reset during WR of SW -> cs/we drop in the same cycle, no resp_valid, req_ready 1. A new request after reset release completes normally.
- BIG_ENDIAN = 1, WAIT_CYCLES = 3: LBU 0x10 -> 0x00000088, resp 5 cycles after accept, cs/oe high 3 cycles. req_valid held high while busy -> no second accept until IDLE.
